vrf_addr_sequencer: RTL



---
 rtl/vrf_addr_sequencer_if.sv | 43 ++++
 rtl/vrf_addr_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vrf_addr_sequencer_if.sv
// Handshake and address bundle between the register-rename/issue side,
// the VRF address sequencer and the lane read/write ports.
// The master modport is the sequencer's view; slave is the environment's view.
interface vrf_addr_sequencer_if #(
    parameter int VLEN      = 4096,
    parameter int VLANE_NUM = 8
);
    localparam int AW = $clog2(VLEN / VLANE_NUM);

    // Instruction hand-off from the renaming stage
    logic              start_vld_i;
    logic              start_rdy_o;
    logic [8*AW-1:0]   base_waddr_i;
    logic [8*AW-1:0]   base_raddr0_i;
    logic [8*AW-1:0]   base_raddr1_i;
    logic [12:0]       vl_i;
    logic [1:0]        sew_i;
    logic [2:0]        lmul_i;
    logic              flush_i;

    // Per-beat address stream toward the lanes
    logic              addr_vld_o;
    logic              addr_rdy_i;
    logic [AW-1:0]     waddr_o;
    logic [AW-1:0]     raddr0_o;
    logic [AW-1:0]     raddr1_o;
    logic              last_o;
    logic              done_o;

    modport master (
        input  start_vld_i, base_waddr_i, base_raddr0_i, base_raddr1_i,
               vl_i, sew_i, lmul_i, flush_i, addr_rdy_i,
        output start_rdy_o, addr_vld_o, waddr_o, raddr0_o, raddr1_o,
               last_o, done_o
    );

    modport slave (
        output start_vld_i, base_waddr_i, base_raddr0_i, base_raddr1_i,
               vl_i, sew_i, lmul_i, flush_i, addr_rdy_i,
        input  start_rdy_o, addr_vld_o, waddr_o, raddr0_o, raddr1_o,
               last_o, done_o
    );
endinterface

// File: rtl/vrf_addr_sequencer.sv
// Per-instruction VRF address stepper. Latches the eight per-register base
// addresses for vd/vs1/vs2 plus vl/SEW/LMUL, then walks the register group
// one word per beat with valid/ready back-pressure, flagging the final beat
// and pulsing done once the instruction has been fully issued.
module vrf_addr_sequencer #(
    parameter int VLEN      = 4096,
    parameter int VLANE_NUM = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    vrf_addr_sequencer_if.master bus
);
    localparam int MEM_DEPTH = VLEN / VLANE_NUM;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int REG_SIZE  = VLEN / 32 / VLANE_NUM;
    localparam int MAXW      = 8 * REG_SIZE;
    localparam int CW        = $clog2(MAXW + 1);
    localparam int REG_SH    = $clog2(REG_SIZE);
    localparam int WORD_SH   = $clog2(4 * VLANE_NUM);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   total;
    logic [8*AW-1:0] base_w;
    logic [8*AW-1:0] base_r0;
    logic [8*AW-1:0] base_r1;

    logic            addr_vld_q;
    logic            last_q;
    logic            done_q;
    logic [AW-1:0]   waddr_q;
    logic [AW-1:0]   raddr0_q;
    logic [AW-1:0]   raddr1_q;

    logic [1:0]      sew_sh;
    logic [3:0]      lmul_regs;
    logic [15:0]     bytes;
    logic [16:0]     words;
    logic [16:0]     limit;
    logic [CW-1:0]   start_total;
    logic [CW-1:0]   cnt_inc;
    logic            accept;
    logic            beat_fire;

    // Word address of beat idx: register slot idx/REG_SIZE, offset idx%REG_SIZE,
    // wrapping modulo the lane memory depth.
    function automatic logic [AW-1:0] beat_addr(input logic [8*AW-1:0] bases,
                                                input logic [CW-1:0]   idx);
        logic [2:0]    slot;
        logic [AW-1:0] off;
        slot = 3'(idx >> REG_SH);
        off  = AW'(idx & CW'(REG_SIZE - 1));
        return bases[32'(slot)*AW +: AW] + off;
    endfunction

    assign bus.start_rdy_o = (state == S_IDLE);
    assign bus.addr_vld_o  = addr_vld_q;
    assign bus.last_o      = last_q;
    assign bus.done_o      = done_q;
    assign bus.waddr_o     = waddr_q;
    assign bus.raddr0_o    = raddr0_q;
    assign bus.raddr1_o    = raddr1_q;

    assign accept    = (state == S_IDLE) && bus.start_vld_i && !bus.flush_i;
    assign beat_fire = addr_vld_q && bus.addr_rdy_i;
    assign cnt_inc   = cnt + CW'(1);

    // Beat count of an incoming instruction: byte length rounded up to whole
    // lane-rows, clamped to the LMUL register group.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sew_sh    = 2'd2;
        lmul_regs = 4'd1;
        case (bus.sew_i)
            2'b00:   sew_sh = 2'd0;
            2'b01:   sew_sh = 2'd1;
            default: sew_sh = 2'd2;
        endcase
        if (!bus.lmul_i[2]) begin
            lmul_regs = 4'd1 << bus.lmul_i[1:0];
        end
        bytes       = 16'(bus.vl_i) << sew_sh;
        words       = ({1'b0, bytes} + 17'(4 * VLANE_NUM - 1)) >> WORD_SH;
        limit       = 17'(lmul_regs) << REG_SH;
        start_total = (words < limit) ? CW'(words) : CW'(limit);
    end

    // Instruction context captured on accept and held for the whole run.
    // NOTE: these registers carry no reset; they are written on every accept before any read.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_w  <= bus.base_waddr_i;
            base_r0 <= bus.base_raddr0_i;
            base_r1 <= bus.base_raddr1_i;
            total   <= start_total;
        end
    end

    // Sequencing state and the registered beat outputs.
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_vld_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            waddr_q    <= '0;
            raddr0_q   <= '0;
            raddr1_q   <= '0;
        end else if (bus.flush_i) begin
            state      <= S_IDLE;
            addr_vld_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_vld_i) begin
                        cnt <= '0;
                        if (start_total == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state      <= S_RUN;
                            addr_vld_q <= 1'b1;
                            last_q     <= (start_total == CW'(1));
                            waddr_q    <= bus.base_waddr_i[AW-1:0];
                            raddr0_q   <= bus.base_raddr0_i[AW-1:0];
                            raddr1_q   <= bus.base_raddr1_i[AW-1:0];
                        end
                    end
                end
                default: begin
                    if (beat_fire) begin
                        if (last_q) begin
                            state      <= S_IDLE;
                            addr_vld_q <= 1'b0;
                            last_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            cnt      <= cnt_inc;
                            last_q   <= (cnt_inc == total - CW'(1));
                            waddr_q  <= beat_addr(base_w, cnt_inc);
                            raddr0_q <= beat_addr(base_r0, cnt_inc);
                            raddr1_q <= beat_addr(base_r1, cnt_inc);
                        end
                    end
                end
            endcase
        end
    end
endmodule
